// File: rtl/core_defs.sv
// Shared core definitions: redirect FSM state encoding, flush counter width,
// and the default interrupt vector, plus a vector-selection helper.
package core_defs;

  // Flush counter width; wide enough for the full legal FLUSH_CYCLES range (1..7).
  localparam int unsigned FLUSH_CNT_W = 3;

  typedef logic [1:0] rc_state_t;

  localparam rc_state_t ST_IDLE      = 2'd0;
  localparam rc_state_t ST_FLUSH     = 2'd1;
  localparam rc_state_t ST_INT_ENTRY = 2'd2;

  localparam logic [31:0] INT_VEC_DEF_RST = 32'h0000_0004;

  // A zero interrupt address means "use the default vector".
  function automatic logic [31:0] pick_int_vec(input logic [31:0] addr,
                                               input logic [31:0] def_vec);
    return (addr == 32'h0) ? def_vec : addr;
  endfunction

endpackage

// File: rtl/redirect_ctrl.sv
// redirect_ctrl: PC redirect / pipeline flush / interrupt entry controller.
//
// Taken branches and (optionally) interrupts become a registered one-cycle
// jump strobe with target, followed by a fixed-length pipeline flush. While
// idle, a stall request freezes the PC unless a redirect is requested.
//
// Optional feature: define REDIRECT_CTRL_INT_EN to enable the interrupt path.
// Without it, int_req_i/int_addr_i/pc_i are ignored and int_ack_o/int_epc_o
// are tied low.
//
// Ports:
//   clk            - clock, rising edge
//   rst_n          - asynchronous active-low reset
//   pc_i           - PC of the instruction in execute (interrupt return PC)
//   ex_jump_en_i   - execute-stage branch/jump taken
//   ex_jump_addr_i - branch/jump target
//   hold_req_i     - load-use / bus stall request
//   int_req_i      - level interrupt request, held until int_ack_o
//   int_addr_i     - interrupt vector (0 selects INT_VEC_DEF)
//   jump_en_o      - registered one-cycle PC redirect strobe
//   jump_addr_o    - registered redirect target, holds last value
//   hold_pc_o      - combinational freeze of PC and IF/ID
//   flush_o        - registered squash of IF/ID/EX
//   int_ack_o      - one-cycle interrupt acceptance pulse
//   int_epc_o      - return PC captured at interrupt entry
module redirect_ctrl
  import core_defs::*;
#(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter logic [31:0] INT_VEC_DEF  = INT_VEC_DEF_RST
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc_i,
  input  logic        ex_jump_en_i,
  input  logic [31:0] ex_jump_addr_i,
  input  logic        hold_req_i,
  input  logic        int_req_i,
  input  logic [31:0] int_addr_i,
  output logic        jump_en_o,
  output logic [31:0] jump_addr_o,
  output logic        hold_pc_o,
  output logic        flush_o,
  output logic        int_ack_o,
  output logic [31:0] int_epc_o
);

  localparam logic [FLUSH_CNT_W-1:0] FlushLoad = FLUSH_CNT_W'(FLUSH_CYCLES - 1);

  rc_state_t              state_q, state_d;
  logic [FLUSH_CNT_W-1:0] cnt_q, cnt_d;
  logic                   jump_en_q, jump_en_d;
  logic [31:0]            jump_addr_q, jump_addr_d;
  logic                   flush_q, flush_d;
  logic                   int_req_eff;

`ifdef REDIRECT_CTRL_INT_EN
  logic        int_ack_q, int_ack_d;
  logic [31:0] int_epc_q, int_epc_d;

  assign int_req_eff = int_req_i;
`else
  logic [31:0] unused_int;

  assign int_req_eff = 1'b0;
  assign unused_int  = {31'h0, int_req_i} ^ int_addr_i ^ pc_i ^ INT_VEC_DEF;
`endif

  // Any redirect request wins over a stall; stalls only apply while idle.
  assign hold_pc_o = hold_req_i & (state_q == ST_IDLE) & ~ex_jump_en_i & ~int_req_eff;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    jump_en_d   = 1'b0;
    jump_addr_d = jump_addr_q;
`ifdef REDIRECT_CTRL_INT_EN
    int_ack_d   = 1'b0;
    int_epc_d   = int_epc_q;
`endif

    case (state_q)
      ST_IDLE: begin
        // Branch has priority; a held interrupt is taken once we are idle again.
        if (ex_jump_en_i) begin
          jump_en_d   = 1'b1;
          jump_addr_d = ex_jump_addr_i;
          state_d     = ST_FLUSH;
          cnt_d       = FlushLoad;
        end
`ifdef REDIRECT_CTRL_INT_EN
        else if (int_req_i) begin
          jump_en_d   = 1'b1;
          jump_addr_d = pick_int_vec(int_addr_i, INT_VEC_DEF);
          int_ack_d   = 1'b1;
          int_epc_d   = pc_i;
          state_d     = ST_INT_ENTRY;
        end
`endif
      end

      ST_FLUSH: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - FLUSH_CNT_W'(1);
        end
      end

`ifdef REDIRECT_CTRL_INT_EN
      // One extra flush cycle for interrupt entry before the normal flush.
      ST_INT_ENTRY: begin
        state_d = ST_FLUSH;
        cnt_d   = FlushLoad;
      end
`endif

      default: state_d = ST_IDLE;
    endcase

    // Flush is asserted for every cycle spent outside IDLE.
    flush_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      jump_en_q   <= 1'b0;
      jump_addr_q <= 32'h0;
      flush_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      jump_en_q   <= jump_en_d;
      jump_addr_q <= jump_addr_d;
      flush_q     <= flush_d;
    end
  end

`ifdef REDIRECT_CTRL_INT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      int_ack_q <= 1'b0;
      int_epc_q <= 32'h0;
    end else begin
      int_ack_q <= int_ack_d;
      int_epc_q <= int_epc_d;
    end
  end

  assign int_ack_o = int_ack_q;
  assign int_epc_o = int_epc_q;
`else
  assign int_ack_o = 1'b0;
  assign int_epc_o = 32'h0;
`endif

  assign jump_en_o   = jump_en_q;
  assign jump_addr_o = jump_addr_q;
  assign flush_o     = flush_q;

endmodule

// File: tb/tb_redirect_ctrl.sv
// Self-checking bench for redirect_ctrl: a cycle model based on a "busy"
// countdown of remaining flush cycles, checked every cycle, plus directed
// literal expectations. Works with or without REDIRECT_CTRL_INT_EN.
module tb_redirect_ctrl;

  localparam int unsigned FC = 2;
`ifdef REDIRECT_CTRL_INT_EN
  localparam bit IntEn = 1'b1;
`else
  localparam bit IntEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] pc_i = '0;
  logic        ex_jump_en_i = 1'b0;
  logic [31:0] ex_jump_addr_i = '0;
  logic        hold_req_i = 1'b0;
  logic        int_req_i = 1'b0;
  logic [31:0] int_addr_i = '0;
  logic        jump_en_o;
  logic [31:0] jump_addr_o;
  logic        hold_pc_o;
  logic        flush_o;
  logic        int_ack_o;
  logic [31:0] int_epc_o;

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_en = 1'b0;

  redirect_ctrl #(
    .FLUSH_CYCLES(FC),
    .INT_VEC_DEF (32'h0000_0004)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pc_i          (pc_i),
    .ex_jump_en_i  (ex_jump_en_i),
    .ex_jump_addr_i(ex_jump_addr_i),
    .hold_req_i    (hold_req_i),
    .int_req_i     (int_req_i),
    .int_addr_i    (int_addr_i),
    .jump_en_o     (jump_en_o),
    .jump_addr_o   (jump_addr_o),
    .hold_pc_o     (hold_pc_o),
    .flush_o       (flush_o),
    .int_ack_o     (int_ack_o),
    .int_epc_o     (int_epc_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: m_busy = flush cycles still to come; idle when it is zero.
  int unsigned m_busy;
  logic        e_jump, e_ack;
  logic [31:0] e_addr, e_epc;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 0;
      e_jump <= 1'b0;
      e_ack  <= 1'b0;
      e_addr <= '0;
      e_epc  <= '0;
    end else begin
      e_jump <= 1'b0;
      e_ack  <= 1'b0;
      if (m_busy == 0) begin
        if (ex_jump_en_i) begin
          e_jump <= 1'b1;
          e_addr <= ex_jump_addr_i;
          m_busy <= FC;
        end else if (IntEn && int_req_i) begin
          e_jump <= 1'b1;
          e_ack  <= 1'b1;
          e_epc  <= pc_i;
          e_addr <= (int_addr_i == 0) ? 32'h4 : int_addr_i;
          m_busy <= FC + 1;
        end
      end else begin
        m_busy <= m_busy - 1;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("m_jump_en", jump_en_o, e_jump);
      chk("m_jump_addr", jump_addr_o, e_addr);
      chk("m_flush", flush_o, m_busy != 0);
      chk("m_int_ack", int_ack_o, e_ack);
      chk("m_int_epc", int_epc_o, e_epc);
      chk("m_hold_pc", hold_pc_o,
          hold_req_i && (m_busy == 0) && !ex_jump_en_i && !(IntEn && int_req_i));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int nflush;
  int ack_idx;
  logic [31:0] ack_epc;

  initial begin
    tick();
    cmp_en = 1'b1;
    tick();
    rst_n = 1'b1;

    // Quiet after reset release.
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_jump_en", jump_en_o, 32'h0);
      chk("idle_flush", flush_o, 32'h0);
      chk("idle_int_ack", int_ack_o, 32'h0);
      chk("idle_hold", hold_pc_o, 32'h0);
    end

    // Plain branch; a second branch during flush must be ignored.
    ex_jump_en_i = 1'b1;
    ex_jump_addr_i = 32'h100;
    tick();
    ex_jump_en_i = 1'b0;
    chk("br_jump_en", jump_en_o, 32'h1);
    chk("br_addr", jump_addr_o, 32'h100);
    chk("br_flush1", flush_o, 32'h1);
    ex_jump_en_i = 1'b1;
    ex_jump_addr_i = 32'h999;
    tick();
    ex_jump_en_i = 1'b0;
    chk("br_pulse", jump_en_o, 32'h0);
    chk("br_flush2", flush_o, 32'h1);
    chk("br_addr_hold", jump_addr_o, 32'h100);
    tick();
    chk("br_flush_end", flush_o, 32'h0);
    chk("br_addr_keep", jump_addr_o, 32'h100);
    tick();

    // Interrupt entry.
    pc_i = 32'h40;
    int_addr_i = 32'h200;
    int_req_i = 1'b1;
    tick();
    int_req_i = 1'b0;
    chk("int_ack", int_ack_o, IntEn ? 32'h1 : 32'h0);
    chk("int_jump_en", jump_en_o, IntEn ? 32'h1 : 32'h0);
    chk("int_addr", jump_addr_o, IntEn ? 32'h200 : 32'h100);
    chk("int_epc", int_epc_o, IntEn ? 32'h40 : 32'h0);
    nflush = int'(flush_o);
    for (int i = 0; i < 8; i++) begin
      tick();
      nflush += int'(flush_o);
    end
    chk("int_flush_len", nflush, IntEn ? FC + 1 : 0);

    // Branch and interrupt together: branch first, interrupt after flush.
    ex_jump_en_i = 1'b1;
    ex_jump_addr_i = 32'h300;
    int_req_i = 1'b1;
    pc_i = 32'h2fc;
    tick();
    ex_jump_en_i = 1'b0;
    pc_i = 32'h300;
    chk("both_jump_en", jump_en_o, 32'h1);
    chk("both_addr", jump_addr_o, 32'h300);
    chk("both_no_ack", int_ack_o, 32'h0);
    ack_idx = 99;
    ack_epc = '0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (int_ack_o && ack_idx == 99) begin
        ack_idx = i;
        ack_epc = int_epc_o;
        int_req_i = 1'b0;
      end
    end
    int_req_i = 1'b0;
    chk("both_ack_cycle", ack_idx, IntEn ? FC : 99);
    chk("both_epc", ack_epc, IntEn ? 32'h300 : 32'h0);
    tick();

    // Zero interrupt address selects the default vector.
    pc_i = 32'h80;
    int_addr_i = 32'h0;
    int_req_i = 1'b1;
    tick();
    int_req_i = 1'b0;
    chk("int_def_vec", jump_addr_o, IntEn ? 32'h4 : 32'h300);
    for (int i = 0; i < 5; i++) tick();

    // Hold vs. redirect.
    hold_req_i = 1'b1;
    ex_jump_en_i = 1'b1;
    ex_jump_addr_i = 32'h500;
    #1;
    chk("hold_vs_jump", hold_pc_o, 32'h0);
    tick();
    ex_jump_en_i = 1'b0;
    chk("hold_jump_taken", jump_en_o, 32'h1);
    chk("hold_jump_addr", jump_addr_o, 32'h500);
    #1;
    chk("hold_in_flush", hold_pc_o, 32'h0);
    tick();
    tick();
    #1;
    chk("hold_alone", hold_pc_o, 32'h1);
    hold_req_i = 1'b0;
    #1;
    chk("hold_release", hold_pc_o, 32'h0);
    tick();

    // Reset in the middle of a flush.
    ex_jump_en_i = 1'b1;
    ex_jump_addr_i = 32'h600;
    tick();
    ex_jump_en_i = 1'b0;
    chk("rst_pre_flush", flush_o, 32'h1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_flush", flush_o, 32'h0);
    chk("rst_jump_en", jump_en_o, 32'h0);
    chk("rst_addr", jump_addr_o, 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("rst_idle_flush", flush_o, 32'h0);
    hold_req_i = 1'b1;
    #1;
    chk("rst_idle_hold", hold_pc_o, 32'h1);
    hold_req_i = 1'b0;
    tick();
    tick();

    cmp_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/redirect_ctrl.md
REDIRECT_CTRL -- requirements
Module: redirect_ctrl

Interface
REQ-001 SHALL have parameter FLUSH_CYCLES, default 2, number of cycles flush_o stays high after any redirect (legal range 1..7).
REQ-002 SHALL have parameter INT_VEC_DEF, default 32'h0000_0004, vector used when int_addr_i is 0.
REQ-003 SHALL have port clk  input  1  single clock; all state on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port pc_i  input  32  PC of the instruction currently in execute.
REQ-006 SHALL have port ex_jump_en_i  input  1  execute-stage branch/jump taken.
REQ-007 SHALL have port ex_jump_addr_i  input  32  branch/jump target.
REQ-008 SHALL have port hold_req_i  input  1  load-use or bus stall request.
REQ-009 SHALL have port int_req_i  input  1  interrupt request, level, held until int_ack_o.
REQ-010 SHALL have port int_addr_i  input  32  interrupt vector, stable while int_req_i is high.
REQ-011 SHALL have port jump_en_o  output  1  registered PC redirect strobe.
REQ-012 SHALL have port jump_addr_o  output  32  registered redirect target.
REQ-013 SHALL have port hold_pc_o  output  1  freeze PC and IF/ID, combinational.
REQ-014 SHALL have port flush_o  output  1  squash IF/ID/EX contents, registered.
REQ-015 SHALL have port int_ack_o  output  1  one-cycle interrupt acceptance pulse.
REQ-016 SHALL have port int_epc_o  output  32  return PC captured at interrupt entry.

Function
REQ-017 SHALL implement FSM states IDLE, FLUSH, INT_ENTRY.
REQ-018 In IDLE with ex_jump_en_i=1: next cycle jump_en_o=1, jump_addr_o=ex_jump_addr_i, flush_o=1, state FLUSH, counter loaded with FLUSH_CYCLES-1.
REQ-019 In IDLE with int_req_i=1 and ex_jump_en_i=0: next cycle state INT_ENTRY, int_epc_o=pc_i, int_ack_o=1, jump_en_o=1, jump_addr_o=int_addr_i (INT_VEC_DEF if 0), flush_o=1.
REQ-020 INT_ENTRY SHALL last exactly one cycle, then go to FLUSH with counter FLUSH_CYCLES-1 (total flush_o high time FLUSH_CYCLES+1 cycles for interrupts).
REQ-021 Simultaneous ex_jump_en_i and int_req_i in IDLE: branch serviced first; interrupt serviced on the first IDLE cycle after the flush completes, int_epc_o then equals the branch target reaching execute.
REQ-022 jump_en_o and int_ack_o SHALL be single-cycle pulses; jump_addr_o holds its last value otherwise.
REQ-023 In FLUSH: flush_o=1, counter decrements each cycle; at counter 0 next state IDLE, flush_o low from that cycle; ex_jump_en_i and int_req_i ignored in FLUSH.
REQ-024 hold_pc_o = hold_req_i AND state==IDLE AND NOT ex_jump_en_i AND NOT int_req_i; redirects always override hold.
REQ-025 Counter width SHALL be 3 bits; no wrap possible within legal FLUSH_CYCLES.
REQ-026 Redirect latency: request cycle N -> jump_en_o cycle N+1 -> new PC cycle N+2.

Reset
REQ-027 On rst_n low, immediately: state IDLE, counter 0, jump_en_o=0, jump_addr_o=0, flush_o=0, int_ack_o=0, int_epc_o=0; hold_pc_o follows REQ-024.
REQ-028 Reset mid-FLUSH or mid-INT_ENTRY SHALL abandon the sequence; no pending interrupt remembered.

Configuration
REQ-029 Macro REDIRECT_CTRL_INT_EN defined: interrupt path per REQ-019..021.
REQ-030 Macro undefined: INT_ENTRY state absent, int_req_i ignored, int_ack_o and int_epc_o tied 0, ports retained.

Structure
REQ-031 FSM state encoding and INT_VEC_DEF default SHALL live in shared package core_defs.
REQ-032 No sub-module; single flat module.

Verification
REQ-033 Reset release, no requests -> all outputs 0 for 10 cycles.
REQ-034 ex_jump_en_i=1, addr 32'h100 at cycle 5 -> jump_en_o=1, jump_addr_o=32'h100 at cycle 6; flush_o high cycles 6-7; IDLE at cycle 8.
REQ-035 int_req_i=1, int_addr_i=32'h200, pc_i=32'h40 -> next cycle int_ack_o=1, jump_addr_o=32'h200, int_epc_o=32'h40; flush_o high 3 cycles.
REQ-036 ex jump 32'h300 and int_req_i same cycle -> jump to 32'h300 first; int_ack_o after flush ends, int_epc_o=32'h300.
REQ-037 hold_req_i=1 with ex jump same cycle -> hold_pc_o=0, redirect taken; hold_req_i alone in IDLE -> hold_pc_o=1 same cycle.
REQ-038 rst_n low during FLUSH -> flush_o=0 immediately, IDLE after release; repeat REQ-035 with macro undefined -> int_ack_o never asserts.
